// File: rtl/snake_anim_pkg.sv
// Shared types, keycode constants and key decoding for the snake animation controller.
package snake_anim_pkg;

   typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;
   typedef enum logic [1:0] {IDLE, WALK, TURN} anim_state_t;

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } key_dec_t;

   // Anything outside the four movement keys, including 0x00, reads as no key.
   function automatic key_dec_t key_to_dir(input logic [7:0] key);
      key_dec_t r;
      r.valid = 1'b1;
      r.dir   = DIR_LEFT;
      case (key)
         KEY_A:   r.dir = DIR_LEFT;
         KEY_D:   r.dir = DIR_RIGHT;
         KEY_W:   r.dir = DIR_UP;
         KEY_S:   r.dir = DIR_DOWN;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_anim_ctrl_vsync_edge_detect.sv
// Two-flop vsync synchronizer with a registered falling-edge pulse (3 clocks after the raw edge).
module vsync_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vsync,
   output logic o_frame_tick
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;
   logic r_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_meta   <= i_vsync;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_tick   <= r_sync_d & ~r_sync;
      end
   end

   assign o_frame_tick = r_tick;

endmodule

// File: rtl/snake_anim_ctrl.sv
// Per-frame walk-cycle sequencer producing the registered {dir, pose} sprite select.
// Optional SNAKE_ANIM_PAUSE_EN adds a pause input that freezes all animation state.
module snake_anim_ctrl
   import snake_anim_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter int NUM_POSES       = 2,
   parameter int TURN_HOLD       = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic [7:0] keycode,
`ifdef SNAKE_ANIM_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] sprite_sel,
   output logic [1:0] dir,
   output logic [1:0] pose,
   output logic       moving,
   output logic       frame_tick
);

   localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
   localparam logic [7:0] HOLD_LAST = 8'(TURN_HOLD - 1);
   localparam logic [1:0] POSE_MASK = 2'(NUM_POSES - 1);

   logic        w_tick;
   logic        w_adv;
   key_dec_t    w_key;

   anim_state_t r_state,      w_state_nxt;
   dir_t        r_dir,        w_dir_nxt;
   logic [1:0]  r_pose,       w_pose_nxt;
   logic [7:0]  r_step_cnt,   w_step_nxt;
   logic [7:0]  r_hold_cnt,   w_hold_nxt;
   logic        r_moving;
   logic [3:0]  r_sprite_sel;

   vsync_edge_detect u_vsync_edge (
      .i_clk        (vga_clk),
      .i_rst_n      (reset_n),
      .i_vsync      (vsync),
      .o_frame_tick (w_tick)
   );

`ifdef SNAKE_ANIM_PAUSE_EN
   assign w_adv = w_tick & ~pause;
`else
   assign w_adv = w_tick;
`endif

   // The live keycode is only consumed on a tick, so it acts as the per-frame sample.
   assign w_key = key_to_dir(keycode);

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_dir        <= DIR_LEFT;
         r_pose       <= 2'd0;
         r_step_cnt   <= 8'd0;
         r_hold_cnt   <= 8'd0;
         r_moving     <= 1'b0;
         r_sprite_sel <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_dir        <= w_dir_nxt;
         r_pose       <= w_pose_nxt;
         r_step_cnt   <= w_step_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_moving     <= (w_state_nxt == WALK);
         r_sprite_sel <= {w_dir_nxt, w_pose_nxt};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_pose_nxt  = r_pose;
      w_step_nxt  = r_step_cnt;
      w_hold_nxt  = r_hold_cnt;
      if (w_adv) begin
         unique case (r_state)
            IDLE: begin
               w_pose_nxt = 2'd0;
               if (w_key.valid) begin
                  if (w_key.dir == r_dir) begin
                     w_state_nxt = WALK;
                     w_step_nxt  = 8'd0;
                  end else begin
                     w_state_nxt = TURN;
                     w_dir_nxt   = w_key.dir;
                     w_hold_nxt  = 8'd0;
                  end
               end
            end
            WALK: begin
               // A direction change outranks a pose step landing on the same tick.
               if (!w_key.valid) begin
                  w_state_nxt = IDLE;
                  w_pose_nxt  = 2'd0;
                  w_step_nxt  = 8'd0;
               end else if (w_key.dir != r_dir) begin
                  w_state_nxt = TURN;
                  w_dir_nxt   = w_key.dir;
                  w_pose_nxt  = 2'd0;
                  w_hold_nxt  = 8'd0;
               end else if (r_step_cnt == STEP_LAST) begin
                  w_step_nxt  = 8'd0;
                  w_pose_nxt  = 2'(r_pose + 2'd1) & POSE_MASK;
               end else begin
                  w_step_nxt  = r_step_cnt + 8'd1;
               end
            end
            TURN: begin
               w_pose_nxt = 2'd0;
               if (w_key.valid && (w_key.dir != r_dir)) begin
                  w_dir_nxt  = w_key.dir;
                  w_hold_nxt = 8'd0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  w_hold_nxt  = 8'd0;
                  w_step_nxt  = 8'd0;
                  w_state_nxt = w_key.valid ? WALK : IDLE;
               end else begin
                  w_hold_nxt = r_hold_cnt + 8'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_pose_nxt  = 2'd0;
            end
         endcase
      end
   end

   assign sprite_sel = r_sprite_sel;
   assign dir        = r_dir;
   assign pose       = r_pose;
   assign moving     = r_moving;
   assign frame_tick = w_tick;

endmodule

// File: tb/tb_snake_anim_ctrl.sv
// Directed bench for snake_anim_ctrl: frame-by-frame vector table plus reset/latency/mid-frame sequences.
module tb_snake_anim_ctrl;

   logic       vga_clk;
   logic       reset_n;
   logic       vsync;
   logic [7:0] keycode;
`ifdef SNAKE_ANIM_PAUSE_EN
   logic       pause;
`endif
   logic [3:0] sprite_sel;
   logic [1:0] dir;
   logic [1:0] pose;
   logic       moving;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   snake_anim_ctrl #(
      .FRAMES_PER_STEP (8),
      .NUM_POSES       (2),
      .TURN_HOLD       (2)
   ) dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .vsync      (vsync),
      .keycode    (keycode),
`ifdef SNAKE_ANIM_PAUSE_EN
      .pause      (pause),
`endif
      .sprite_sel (sprite_sel),
      .dir        (dir),
      .pose       (pose),
      .moving     (moving),
      .frame_tick (frame_tick)
   );

   // clock / reset
   initial vga_clk = 1'b0;
   always #20 vga_clk = ~vga_clk;

   typedef struct {
      logic [7:0] key;
      int         reps;
      logic [1:0] exp_dir;
      logic [1:0] exp_pose;
      logic       exp_mov;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full vsync frame; returns how many cycles frame_tick was high.
   task automatic do_frame(input logic [7:0] key, output int ticks);
      keycode = key;
      ticks   = 0;
      @(negedge vga_clk);
      vsync = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge vga_clk);
         if (i == 5) vsync = 1'b1;
         if (frame_tick) ticks++;
      end
   endtask

   task automatic check_outs(input string name, input logic [1:0] d, input logic [1:0] p, input logic m);
      check({name, " dir"},        dir,        d);
      check({name, " pose"},       pose,       p);
      check({name, " moving"},     moving,     m);
      check({name, " sprite_sel"}, sprite_sel, {d, p});
   endtask

   initial begin
      int ticks;
      int lat;
      reset_n = 1'b0;
      vsync   = 1'b1;
      keycode = 8'h00;
`ifdef SNAKE_ANIM_PAUSE_EN
      pause   = 1'b0;
`endif

      // vector table
      vecs.push_back('{8'h00, 3, 2'd0, 2'd0, 1'b0});
      vecs.push_back('{8'h04, 8, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h04, 8, 2'd0, 2'd1, 1'b1});
      vecs.push_back('{8'h04, 8, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h04, 8, 2'd0, 2'd1, 1'b1});
      vecs.push_back('{8'h04, 1, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h04, 7, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h04, 1, 2'd0, 2'd1, 1'b1});
      vecs.push_back('{8'h07, 2, 2'd1, 2'd0, 1'b0});
      vecs.push_back('{8'h07, 1, 2'd1, 2'd0, 1'b1});
      vecs.push_back('{8'h07, 7, 2'd1, 2'd0, 1'b1});
      vecs.push_back('{8'h07, 1, 2'd1, 2'd1, 1'b1});
      vecs.push_back('{8'h07, 7, 2'd1, 2'd1, 1'b1});
      vecs.push_back('{8'h1A, 1, 2'd2, 2'd0, 1'b0});
      vecs.push_back('{8'h00, 4, 2'd2, 2'd0, 1'b0});
      vecs.push_back('{8'h16, 1, 2'd3, 2'd0, 1'b0});
      vecs.push_back('{8'h04, 2, 2'd0, 2'd0, 1'b0});
      vecs.push_back('{8'h04, 1, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h05, 1, 2'd0, 2'd0, 1'b0});
      vecs.push_back('{8'h04, 8, 2'd0, 2'd0, 1'b1});
      vecs.push_back('{8'h04, 1, 2'd0, 2'd1, 1'b1});
      vecs.push_back('{8'h16, 2, 2'd3, 2'd0, 1'b0});
      vecs.push_back('{8'h16, 8, 2'd3, 2'd0, 1'b1});
      vecs.push_back('{8'h16, 1, 2'd3, 2'd1, 1'b1});

      // reset state
      repeat (3) @(negedge vga_clk);
      check_outs("reset", 2'd0, 2'd0, 1'b0);
      check("reset frame_tick", frame_tick, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge vga_clk);

      // frame_tick latency from the raw falling edge
      vsync = 1'b0;
      lat   = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge vga_clk);
         if (frame_tick && lat < 0) lat = i;
      end
      vsync = 1'b1;
      check("tick latency", lat, 3);
      repeat (6) @(negedge vga_clk);
      check_outs("after first tick", 2'd0, 2'd0, 1'b0);

      // table-driven frames
      for (int v = 0; v < vecs.size(); v++) begin
         for (int r = 0; r < vecs[v].reps; r++) begin
            do_frame(vecs[v].key, ticks);
            check($sformatf("vec%0d.%0d tick width", v, r), ticks, 1);
            check_outs($sformatf("vec%0d.%0d", v, r), vecs[v].exp_dir, vecs[v].exp_pose, vecs[v].exp_mov);
         end
      end

      // mid-frame key changes without a tick must not move anything
      keycode = 8'h04;
      repeat (3) @(negedge vga_clk);
      keycode = 8'h1A;
      repeat (3) @(negedge vga_clk);
      keycode = 8'h16;
      repeat (2) @(negedge vga_clk);
      check_outs("mid-frame key", 2'd3, 2'd1, 1'b1);

      // async reset during WALK DOWN pose 1
      reset_n = 1'b0;
      #1;
      check_outs("async reset", 2'd0, 2'd0, 1'b0);
      repeat (5) @(negedge vga_clk);
      check_outs("reset held", 2'd0, 2'd0, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge vga_clk);
      do_frame(8'h16, ticks);
      check("post-reset tick width", ticks, 1);
      check_outs("post-reset turn", 2'd3, 2'd0, 1'b0);
      do_frame(8'h16, ticks);
      check_outs("post-reset hold", 2'd3, 2'd0, 1'b0);
      do_frame(8'h16, ticks);
      check_outs("post-reset walk", 2'd3, 2'd0, 1'b1);

`ifdef SNAKE_ANIM_PAUSE_EN
      for (int i = 0; i < 3; i++) do_frame(8'h16, ticks);
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         do_frame(i[0] ? 8'h04 : 8'h00, ticks);
         check("paused tick width", ticks, 1);
         check_outs("paused", 2'd3, 2'd0, 1'b1);
      end
      pause = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_frame(8'h16, ticks);
         check_outs("resume hold pose", 2'd3, 2'd0, 1'b1);
      end
      do_frame(8'h16, ticks);
      check_outs("resume step", 2'd3, 2'd1, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
